// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - FSM that fills CR16 datapath registers with a Fibonacci or arithmetic sequence
// Outputs are registered from the next state, so each state's controls are visible for the whole state cycle.
module datapath_sequencer #(
  parameter int         DATA_WIDTH = 16,
  parameter int         NUM_REGS   = 16,
  parameter int         SEL_WIDTH  = 4,
  parameter int         SEQ_LEN    = 8,
  parameter logic [3:0] OPCODE_ADD = 4'd1
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic                  I_START,
  input  logic                  I_MODE,
  input  logic [DATA_WIDTH-1:0] I_SEED0,
  input  logic [DATA_WIDTH-1:0] I_SEED1,
  input  logic [DATA_WIDTH-1:0] I_STEP,
  input  logic                  I_STOP_ON_CARRY,
  input  logic                  I_CARRY,
  output logic                  O_DATAPATH_NRESET,
  output logic [NUM_REGS-1:0]   O_REG_WRITE_ENABLE,
  output logic [SEL_WIDTH-1:0]  O_REG_A_SELECT,
  output logic [SEL_WIDTH-1:0]  O_REG_B_SELECT,
  output logic [DATA_WIDTH-1:0] O_IMMEDIATE,
  output logic                  O_IMMEDIATE_SELECT,
  output logic [3:0]            O_OPCODE,
  output logic                  O_BUSY,
  output logic                  O_DONE,
  output logic                  O_OVERFLOW,
  output logic [SEL_WIDTH:0]    O_COUNT
);

  generate
    if (SEQ_LEN < 2 || SEQ_LEN > NUM_REGS) begin : g_bad_seq_len
      $error("datapath_sequencer: SEQ_LEN must be within 2..NUM_REGS");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SEED0, S_SEED1, S_STEP, S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [SEL_WIDTH-1:0]  k, k_nxt;
  logic                  mode_q, stop_q;
  logic [DATA_WIDTH-1:0] seed0_q, seed1_q, step_q;

  logic                  nreset_nxt, imm_sel_nxt, busy_nxt, done_nxt, overflow_nxt;
  logic [NUM_REGS-1:0]   we_nxt;
  logic [SEL_WIDTH-1:0]  a_nxt, b_nxt;
  logic [DATA_WIDTH-1:0] imm_nxt;
  logic [3:0]            op_nxt;
  logic [SEL_WIDTH:0]    count_nxt;

  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    nreset_nxt   = 1'b1;
    we_nxt       = '0;
    a_nxt        = '0;
    b_nxt        = '0;
    imm_nxt      = '0;
    imm_sel_nxt  = 1'b0;
    op_nxt       = 4'd0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    overflow_nxt = O_OVERFLOW;
    count_nxt    = O_COUNT + {{SEL_WIDTH{1'b0}}, |O_REG_WRITE_ENABLE};

    case (state)
      S_IDLE:  if (I_START) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_SEED0;
      S_SEED0: begin
        if (mode_q) begin
          state_nxt = S_STEP;
          k_nxt     = SEL_WIDTH'(1);
        end else begin
          state_nxt = S_SEED1;
        end
      end
      S_SEED1: begin
        state_nxt = S_STEP;
        k_nxt     = SEL_WIDTH'(2);
      end
      S_STEP: begin
        // The carrying write still lands this cycle; only the following steps are skipped.
        if (I_CARRY) overflow_nxt = 1'b1;
        if ((I_CARRY && stop_q) || k == SEL_WIDTH'(SEQ_LEN - 1)) begin
          state_nxt = S_DONE;
        end else begin
          k_nxt = k + SEL_WIDTH'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_CLEAR: begin
        nreset_nxt   = 1'b0;
        busy_nxt     = 1'b1;
        overflow_nxt = 1'b0;
        count_nxt    = '0;
      end
      S_SEED0: begin
        we_nxt      = NUM_REGS'(1);
        imm_nxt     = seed0_q;
        imm_sel_nxt = 1'b1;
        op_nxt      = OPCODE_ADD;
        busy_nxt    = 1'b1;
      end
      S_SEED1: begin
        we_nxt      = NUM_REGS'(2);
        a_nxt       = SEL_WIDTH'(1);
        imm_nxt     = seed1_q;
        imm_sel_nxt = 1'b1;
        op_nxt      = OPCODE_ADD;
        busy_nxt    = 1'b1;
      end
      S_STEP: begin
        we_nxt   = NUM_REGS'(1) << k_nxt;
        op_nxt   = OPCODE_ADD;
        busy_nxt = 1'b1;
        if (mode_q) begin
          a_nxt       = k_nxt - SEL_WIDTH'(1);
          imm_nxt     = step_q;
          imm_sel_nxt = 1'b1;
        end else begin
          a_nxt = k_nxt - SEL_WIDTH'(2);
          b_nxt = k_nxt - SEL_WIDTH'(1);
        end
      end
      S_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state              <= S_IDLE;
      k                  <= '0;
      mode_q             <= 1'b0;
      stop_q             <= 1'b0;
      seed0_q            <= '0;
      seed1_q            <= '0;
      step_q             <= '0;
      O_DATAPATH_NRESET  <= 1'b1;
      O_REG_WRITE_ENABLE <= '0;
      O_REG_A_SELECT     <= '0;
      O_REG_B_SELECT     <= '0;
      O_IMMEDIATE        <= '0;
      O_IMMEDIATE_SELECT <= 1'b0;
      O_OPCODE           <= 4'd0;
      O_BUSY             <= 1'b0;
      O_DONE             <= 1'b0;
      O_OVERFLOW         <= 1'b0;
      O_COUNT            <= '0;
    end else begin
      state              <= state_nxt;
      k                  <= k_nxt;
      O_DATAPATH_NRESET  <= nreset_nxt;
      O_REG_WRITE_ENABLE <= we_nxt;
      O_REG_A_SELECT     <= a_nxt;
      O_REG_B_SELECT     <= b_nxt;
      O_IMMEDIATE        <= imm_nxt;
      O_IMMEDIATE_SELECT <= imm_sel_nxt;
      O_OPCODE           <= op_nxt;
      O_BUSY             <= busy_nxt;
      O_DONE             <= done_nxt;
      O_OVERFLOW         <= overflow_nxt;
      O_COUNT            <= count_nxt;
      if (state == S_IDLE && I_START) begin
        mode_q  <= I_MODE;
        stop_q  <= I_STOP_ON_CARRY;
        seed0_q <= I_SEED0;
        seed1_q <= I_SEED1;
        step_q  <= I_STEP;
      end
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - randomized bench for datapath_sequencer with a stand-in datapath
// Expected register contents come from a plain-arithmetic sequence model.
module tb_datapath_sequencer;
  localparam int         DW = 16;
  localparam int         NR = 16;
  localparam int         SW = 4;
  localparam int         SL = 8;
  localparam logic [3:0] OP_ADD = 4'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, mode = 1'b0, stop_on_carry = 1'b0;
  logic [DW-1:0] seed0 = '0, seed1 = '0, step = '0;
  logic          carry;
  logic          dp_nreset, imm_sel, busy, done, overflow;
  logic [NR-1:0] we;
  logic [SW-1:0] a_sel, b_sel;
  logic [DW-1:0] imm;
  logic [3:0]    opcode;
  logic [SW:0]   count;

  always #5 clk = ~clk;

  datapath_sequencer #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_WIDTH(SW), .SEQ_LEN(SL), .OPCODE_ADD(OP_ADD)
  ) dut (
    .I_CLK(clk), .I_RESET(rst), .I_START(start), .I_MODE(mode),
    .I_SEED0(seed0), .I_SEED1(seed1), .I_STEP(step),
    .I_STOP_ON_CARRY(stop_on_carry), .I_CARRY(carry),
    .O_DATAPATH_NRESET(dp_nreset), .O_REG_WRITE_ENABLE(we),
    .O_REG_A_SELECT(a_sel), .O_REG_B_SELECT(b_sel),
    .O_IMMEDIATE(imm), .O_IMMEDIATE_SELECT(imm_sel), .O_OPCODE(opcode),
    .O_BUSY(busy), .O_DONE(done), .O_OVERFLOW(overflow), .O_COUNT(count)
  );

  // Stand-in datapath: register file with an unsigned adder and carry-out.
  logic [DW-1:0] dp_reg [NR];
  logic [DW:0]   sum;
  always_comb sum = {1'b0, dp_reg[a_sel]} + {1'b0, (imm_sel ? imm : dp_reg[b_sel])};
  assign carry = (opcode == OP_ADD) && sum[DW];
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (!dp_nreset) dp_reg[i] <= '0;
      else if (we[i]) dp_reg[i] <= sum[DW-1:0];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model results
  logic [DW-1:0] exp_reg [NR];
  int            exp_n;
  bit            exp_ovf;

  // Observations from one run (sample i is taken at the falling edge after rising edge i, edge 0 accepts start)
  logic [NR-1:0] obs_we [48];
  bit            obs_busy [48];
  bit            obs_ovf [48];
  int            done_idx, done_cnt, nrl_cnt, nrl_first;
  logic [SW:0]   cnt_at_done;
  bit            ovf_at_done;

  task automatic model(input bit m, input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                       input logic [DW-1:0] st, input bit stp);
    int vals [NR];
    int total;
    for (int i = 0; i < NR; i++) vals[i] = 0;
    vals[0] = int'(s0);
    if (!m) vals[1] = int'(s1);
    exp_n   = m ? 1 : 2;
    exp_ovf = 1'b0;
    for (int k = exp_n; k < SL; k++) begin
      total   = m ? vals[k-1] + int'(st) : vals[k-2] + vals[k-1];
      vals[k] = total % 65536;
      exp_n   = k + 1;
      if (total > 65535) begin
        exp_ovf = 1'b1;
        if (stp) break;
      end
    end
    for (int i = 0; i < NR; i++) exp_reg[i] = DW'(vals[i]);
  endtask

  task automatic run_seq(input bit hold);
    done_idx = -1; done_cnt = 0; nrl_cnt = 0; nrl_first = -1;
    cnt_at_done = '0; ovf_at_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (i == 0) begin
        // inputs must have been latched; scramble them
        mode = 1'($urandom); stop_on_carry = 1'($urandom);
        seed0 = DW'($urandom); seed1 = DW'($urandom); step = DW'($urandom);
      end
      obs_we[i] = we; obs_busy[i] = busy; obs_ovf[i] = overflow;
      if (!dp_nreset) begin
        nrl_cnt++;
        if (nrl_first < 0) nrl_first = i;
      end
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx = i; cnt_at_done = count; ovf_at_done = overflow;
        end
      end
      if (done_idx >= 0 && i >= done_idx + 1) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (dp_nreset !== 1'b1) begin
      miscompares++; $display("FAIL reset_nreset: got %b want 1", dp_nreset);
    end
    vectors++;
    if ({we, a_sel, b_sel, imm, imm_sel, opcode, busy, done, overflow, count} !== '0) begin
      miscompares++;
      $display("FAIL reset_zero: we=%h a=%h b=%h imm=%h isel=%b op=%h busy=%b done=%b ovf=%b cnt=%0d want all 0",
               we, a_sel, b_sel, imm, imm_sel, opcode, busy, done, overflow, count);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL idle_quiet: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_fibonacci();
    logic [DW-1:0] s0, s1;
    logic [NR-1:0] we_exp;
    bit            stp;
    for (int t = 0; t < 6; t++) begin
      s0  = (t == 0) ? DW'(1) : (t < 3 ? DW'($urandom_range(0, 400)) : DW'($urandom));
      s1  = (t == 0) ? DW'(1) : (t < 3 ? DW'($urandom_range(0, 400)) : DW'($urandom));
      stp = (t == 0) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      mode = 1'b0; seed0 = s0; seed1 = s1; step = DW'($urandom); stop_on_carry = stp;
      model(1'b0, s0, s1, '0, stp);
      run_seq(1'b0);
      vectors++;
      if (done_idx != exp_n + 1 || done_cnt != 1) begin
        miscompares++;
        $display("FAIL fib_done[%0d]: done at sample %0d (x%0d) want sample %0d once", t, done_idx, done_cnt, exp_n + 1);
      end
      vectors++;
      if (cnt_at_done !== (SW+1)'(exp_n) || ovf_at_done !== exp_ovf) begin
        miscompares++;
        $display("FAIL fib_count_ovf[%0d]: count=%0d ovf=%b want %0d %b", t, cnt_at_done, ovf_at_done, exp_n, exp_ovf);
      end
      vectors++;
      if (nrl_cnt != 1 || nrl_first != 0) begin
        miscompares++; $display("FAIL fib_clear[%0d]: nreset low %0d cycles from %0d want 1 from 0", t, nrl_cnt, nrl_first);
      end
      for (int j = 0; j <= exp_n + 1; j++) begin
        we_exp = (j >= 1 && j <= exp_n) ? NR'(1) << (j - 1) : '0;
        vectors++;
        if (obs_we[j] !== we_exp) begin
          miscompares++; $display("FAIL fib_we[%0d][%0d]: got %h want %h", t, j, obs_we[j], we_exp);
        end
      end
      for (int i = 0; i < NR; i++) begin
        vectors++;
        if (dp_reg[i] !== exp_reg[i]) begin
          miscompares++; $display("FAIL fib_reg[%0d] r%0d: got %h want %h", t, i, dp_reg[i], exp_reg[i]);
        end
      end
    end
  endtask

  task automatic test_arithmetic();
    logic [DW-1:0] s0, st;
    bit            stp;
    for (int t = 0; t < 6; t++) begin
      s0  = (t == 0) ? DW'(5) : (t < 3 ? DW'($urandom_range(0, 1000)) : DW'($urandom));
      st  = (t == 0) ? DW'(3) : (t < 3 ? DW'($urandom_range(0, 1000)) : DW'($urandom));
      stp = (t == 0) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      mode = 1'b1; seed0 = s0; seed1 = DW'($urandom); step = st; stop_on_carry = stp;
      model(1'b1, s0, '0, st, stp);
      run_seq(1'b0);
      if (t == 0) begin
        vectors++;
        if (dp_reg[7] !== 16'd26 || overflow !== 1'b0) begin
          miscompares++; $display("FAIL arith_5_3: r7=%0d ovf=%b want 26 0", dp_reg[7], overflow);
        end
      end
      vectors++;
      if (done_idx != exp_n + 1 || cnt_at_done !== (SW+1)'(exp_n) || ovf_at_done !== exp_ovf) begin
        miscompares++;
        $display("FAIL arith_run[%0d]: done@%0d cnt=%0d ovf=%b want done@%0d cnt=%0d ovf=%b",
                 t, done_idx, cnt_at_done, ovf_at_done, exp_n + 1, exp_n, exp_ovf);
      end
      for (int j = 0; j <= exp_n + 1; j++) begin
        vectors++;
        if (obs_busy[j] !== (j <= exp_n)) begin
          miscompares++; $display("FAIL arith_busy[%0d][%0d]: got %b want %b", t, j, obs_busy[j], j <= exp_n);
        end
      end
      for (int i = 0; i < NR; i++) begin
        vectors++;
        if (dp_reg[i] !== exp_reg[i]) begin
          miscompares++; $display("FAIL arith_reg[%0d] r%0d: got %h want %h", t, i, dp_reg[i], exp_reg[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    for (int s = 1; s >= 0; s--) begin
      @(negedge clk);
      mode = 1'b1; seed0 = 16'hFFF0; step = 16'h0010; stop_on_carry = 1'(s);
      model(1'b1, 16'hFFF0, '0, 16'h0010, 1'(s));
      run_seq(1'b0);
      vectors++;
      if (dp_reg[1] !== 16'h0000 || ovf_at_done !== 1'b1 || overflow !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_flag[stop=%0d]: r1=%h ovf_done=%b ovf_idle=%b want 0000 1 1", s, dp_reg[1], ovf_at_done, overflow);
      end
      vectors++;
      if (cnt_at_done !== (s ? 5'd2 : 5'd8) || done_idx != (s ? 3 : SL + 1)) begin
        miscompares++;
        $display("FAIL ovf_len[stop=%0d]: count=%0d done@%0d want %0d done@%0d", s, cnt_at_done, done_idx, s ? 2 : 8, s ? 3 : SL + 1);
      end
      for (int i = 0; i < NR; i++) begin
        vectors++;
        if (dp_reg[i] !== exp_reg[i]) begin
          miscompares++; $display("FAIL ovf_reg[stop=%0d] r%0d: got %h want %h", s, i, dp_reg[i], exp_reg[i]);
        end
      end
    end
  endtask

  task automatic test_start_held();
    @(negedge clk);
    mode = 1'b1; seed0 = 16'hFFF0; step = 16'h0010; stop_on_carry = 1'b0;
    run_seq(1'b1);
    vectors++;
    if (nrl_cnt != 1 || done_cnt != 1 || done_idx != SL + 1) begin
      miscompares++;
      $display("FAIL held_start: clears=%0d dones=%0d done@%0d want 1 1 %0d", nrl_cnt, done_cnt, done_idx, SL + 1);
    end
    @(negedge clk);
    vectors++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL held_sticky: ovf=%b busy=%b want 1 0", overflow, busy);
    end
    mode = 1'b1; seed0 = DW'(5); step = DW'(3); stop_on_carry = 1'b0;
    model(1'b1, DW'(5), '0, DW'(3), 1'b0);
    run_seq(1'b0);
    vectors++;
    if (obs_ovf[0] !== 1'b0 || ovf_at_done !== 1'b0) begin
      miscompares++; $display("FAIL restart_ovf_clear: clear=%b done=%b want 0 0", obs_ovf[0], ovf_at_done);
    end
    vectors++;
    if (nrl_cnt != 1 || nrl_first != 0) begin
      miscompares++; $display("FAIL restart_nreset: low %0d cycles from %0d want 1 from 0", nrl_cnt, nrl_first);
    end
    for (int i = 0; i < NR; i++) begin
      vectors++;
      if (dp_reg[i] !== exp_reg[i]) begin
        miscompares++; $display("FAIL restart_reg r%0d: got %h want %h", i, dp_reg[i], exp_reg[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int  waited;
    bit  saw_done;
    @(negedge clk);
    mode = 1'b0; seed0 = DW'(1); seed1 = DW'(1); stop_on_carry = 1'b0;
    start = 1'b1;
    @(posedge clk);
    waited = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      waited++;
    end while (we !== NR'(16) && waited < 20);
    vectors++;
    if (we !== NR'(16)) begin
      miscompares++; $display("FAIL midrst_reach_k4: we=%h want 0010 within 20 cycles", we);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (dp_nreset !== 1'b1 || {we, a_sel, b_sel, imm, imm_sel, opcode, busy, done, overflow, count} !== '0) begin
      miscompares++;
      $display("FAIL midrst_async: nreset=%b we=%h a=%h b=%h busy=%b cnt=%0d want 1 and all 0",
               dp_nreset, we, a_sel, b_sel, busy, count);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++; $display("FAIL midrst_no_done: got done pulse want none");
    end
    mode = 1'b0; seed0 = DW'(1); seed1 = DW'(1); stop_on_carry = 1'b0;
    model(1'b0, DW'(1), DW'(1), '0, 1'b0);
    run_seq(1'b0);
    vectors++;
    if (done_idx != SL + 1 || cnt_at_done !== 5'd8 || dp_reg[7] !== 16'd21) begin
      miscompares++;
      $display("FAIL midrst_rerun: done@%0d cnt=%0d r7=%0d want %0d 8 21", done_idx, cnt_at_done, dp_reg[7], SL + 1);
    end
    for (int i = 0; i < NR; i++) begin
      vectors++;
      if (dp_reg[i] !== exp_reg[i]) begin
        miscompares++; $display("FAIL midrst_reg r%0d: got %h want %h", i, dp_reg[i], exp_reg[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fibonacci();
    test_arithmetic();
    test_overflow();
    test_start_held();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
